// File: rtl/serving_spiflash_pkg.sv
// Shared types and constants for the SPI flash Wishbone read bridge.
package serving_spiflash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ACK,
        ST_CSGAP
    } state_t;

    localparam logic [7:0] READ_CMD  = 8'h03;
    localparam int         CMD_BITS  = 8;
    localparam int         ADDR_BITS = 24;
    localparam int         DATA_BITS = 32;
    localparam int         CSGAP_LEN = 2;

    // Bit-counter values of the last bit in each phase of the 64-bit frame.
    localparam logic [5:0] CMD_LAST  = 6'(CMD_BITS - 1);
    localparam logic [5:0] ADDR_LAST = 6'(CMD_BITS + ADDR_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(CMD_BITS + ADDR_BITS + DATA_BITS - 1);

    // Flash streams bytes in ascending address order; the first byte
    // received belongs in the least significant lane of the bus word.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/serving_spiflash.sv
// Wishbone-classic read-only slave fetching 32-bit words from SPI NOR flash.
//
// Handshake: a request is i_wb_stb held high until o_wb_ack pulses for one
// cycle; reads start a READ (0x03) SPI frame, writes are acknowledged the
// next cycle and discarded. While o_wb_ack is high the held strobe is not
// taken as a new request.
module serving_spiflash
    import serving_spiflash_pkg::*;
#(
    parameter int             AW         = 24,
    parameter logic [AW-1:0]  FLASH_BASE = AW'(24'h100000)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_spi_sck,
    output logic        o_spi_cs_n,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso
);

    state_t      r_state, w_state;
    logic [5:0]  r_cnt,   w_cnt;
    logic [1:0]  r_gap,   w_gap;
    logic [31:0] r_sr,    w_sr;
    logic        r_sck,   w_sck;
    logic        r_cs_n,  w_cs_n;
    logic        r_mosi,  w_mosi;
    logic        r_ack,   w_ack;
    logic [31:0] r_rdt,   w_rdt;

    logic [AW-1:0] w_flash_adr;
    logic [23:0]   w_tx_adr;
    logic          w_unused_bits;

    // Word-aligned bus address shifted into the flash window, wrapping at 2^AW.
    assign w_flash_adr   = FLASH_BASE + {i_wb_adr[AW-1:2], 2'b00};
    assign w_tx_adr      = 24'(w_flash_adr);
    assign w_unused_bits = ^{i_wb_dat, i_wb_sel, i_wb_adr[31:AW], i_wb_adr[1:0]};

    // Next-state and datapath: each SPI bit is one low and one high sck phase;
    // MOSI moves on the falling edge, MISO is captured on the rising edge.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        w_sr    = r_sr;
        w_sck   = r_sck;
        w_cs_n  = r_cs_n;
        w_mosi  = r_mosi;
        w_ack   = 1'b0;
        w_rdt   = r_rdt;
        case (r_state)
            ST_IDLE: begin
                if (i_wb_stb && !r_ack) begin
                    if (i_wb_we) begin
                        w_ack = 1'b1;
                    end else begin
                        w_state = ST_CMD;
                        w_cs_n  = 1'b0;
                        w_sck   = 1'b0;
                        w_cnt   = 6'd0;
                        w_mosi  = READ_CMD[7];
                        w_sr    = {READ_CMD[6:0], w_tx_adr, 1'b0};
                    end
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (!r_sck) begin
                    w_sck = 1'b1;
                    if (r_state == ST_DATA) begin
                        w_sr = {r_sr[30:0], i_spi_miso};
                    end
                end else begin
                    w_sck = 1'b0;
                    w_cnt = r_cnt + 6'd1;
                    if (r_state != ST_DATA) begin
                        w_mosi = r_sr[31];
                        w_sr   = {r_sr[30:0], 1'b0};
                    end
                    if (r_cnt == CMD_LAST) begin
                        w_state = ST_ADDR;
                    end
                    if (r_cnt == ADDR_LAST) begin
                        w_state = ST_DATA;
                        w_mosi  = 1'b0;
                    end
                    if (r_cnt == DATA_LAST) begin
                        w_state = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                w_ack   = 1'b1;
                w_cs_n  = 1'b1;
                w_rdt   = byte_swap(r_sr);
                w_gap   = 2'd0;
                w_state = ST_CSGAP;
            end
            ST_CSGAP: begin
                if (r_gap == 2'(CSGAP_LEN - 1)) begin
                    w_state = ST_IDLE;
                end else begin
                    w_gap = r_gap + 2'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
            r_gap   <= 2'd0;
            r_sr    <= 32'd0;
            r_sck   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_ack   <= 1'b0;
            r_rdt   <= 32'd0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_sr    <= w_sr;
            r_sck   <= w_sck;
            r_cs_n  <= w_cs_n;
            r_mosi  <= w_mosi;
            r_ack   <= w_ack;
            r_rdt   <= w_rdt;
        end
    end

    assign o_wb_rdt   = r_rdt;
    assign o_wb_ack   = r_ack;
    assign o_spi_sck  = r_sck;
    assign o_spi_cs_n = r_cs_n;
    assign o_spi_mosi = r_mosi;

endmodule

// File: tb/tb_serving_spiflash.sv
// Bench for serving_spiflash: behavioural SPI flash model plus directed and
// random Wishbone reads/writes checked against address/data rules.
module tb_serving_spiflash;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_spi_sck;
    logic        o_spi_cs_n;
    logic        o_spi_mosi;
    logic        i_spi_miso = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_drive, t_ack;

    logic [31:0] exp_q[$];
    logic [31:0] hdr_q[$];
    logic [7:0]  ovr[logic [23:0]];
    logic [7:0]  seed;
    logic        rst_seen = 1'b1;

    serving_spiflash dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wb_adr   (i_wb_adr),
        .i_wb_dat   (i_wb_dat),
        .i_wb_sel   (i_wb_sel),
        .i_wb_we    (i_wb_we),
        .i_wb_stb   (i_wb_stb),
        .o_wb_rdt   (o_wb_rdt),
        .o_wb_ack   (o_wb_ack),
        .o_spi_sck  (o_spi_sck),
        .o_spi_cs_n (o_spi_cs_n),
        .o_spi_mosi (o_spi_mosi),
        .i_spi_miso (i_spi_miso)
    );

    // Clock, cycle counter and reset tracker.
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) begin
        cyc      <= cyc + 1;
        rst_seen <= i_rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash contents: a few pinned bytes, everything else a seeded pattern.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        if (ovr.exists(a)) return ovr[a];
        return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ seed;
    endfunction

    function automatic logic [23:0] exp_addr(input logic [31:0] adr);
        return 24'h100000 + {adr[23:2], 2'b00};
    endfunction

    function automatic logic [31:0] exp_hdr(input logic [31:0] adr);
        return {8'h03, exp_addr(adr)};
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] adr);
        logic [23:0] a;
        a = exp_addr(adr);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // Flash model and SPI protocol checks, sampled mid-cycle.
    int          bits  = 0;
    int          cs_hi = 0;
    logic [31:0] hdr   = 32'd0;
    logic        prev_sck = 1'b0, prev_csn = 1'b1, prev_mosi = 1'b0;
    logic [31:0] prev_rdt = 32'd0;
    always @(negedge i_clk) begin
        int          j;
        logic [23:0] fa;
        logic [7:0]  fb;
        if (!rst_seen) begin
            if (o_spi_cs_n) begin
                check("idle_mosi", {31'd0, o_spi_mosi}, 32'd0);
                check("idle_sck", {31'd0, o_spi_sck}, 32'd0);
            end
            if (o_spi_mosi !== prev_mosi)
                check("mosi_on_fall", {31'd0, (!o_spi_sck && (prev_sck || prev_csn))}, 32'd1);
            if (!o_spi_cs_n && bits >= 32)
                check("data_mosi", {31'd0, o_spi_mosi}, 32'd0);
            if (o_wb_rdt !== prev_rdt)
                check("rdt_hold", {31'd0, o_wb_ack}, 32'd1);
            if (!o_spi_cs_n && prev_csn)
                check("cs_gap", {31'd0, (cs_hi >= 2)}, 32'd1);
        end
        if (o_spi_cs_n) begin
            if (!prev_csn && bits == 64) hdr_q.push_back(hdr);
            bits = 0;
            cs_hi++;
            i_spi_miso = 1'b0;
        end else begin
            cs_hi = 0;
            if (o_spi_sck && !prev_sck) begin
                if (bits < 32) hdr = {hdr[30:0], o_spi_mosi};
                bits++;
            end
            if (!o_spi_sck) begin
                if (bits >= 32) begin
                    j  = bits - 32;
                    fa = hdr[23:0] + 24'(j / 8);
                    fb = fbyte(fa);
                    i_spi_miso = fb[7 - (j % 8)];
                end else begin
                    i_spi_miso = 1'b0;
                end
            end
        end
        prev_sck  = o_spi_sck;
        prev_csn  = o_spi_cs_n;
        prev_mosi = o_spi_mosi;
        prev_rdt  = o_wb_rdt;
    end

    // Driver: issue a read and wait (bounded) for its ack; optionally drop stb early.
    task automatic do_read(input logic [31:0] adr, input int drop_after);
        int   n;
        logic got;
        i_wb_adr = adr;
        i_wb_dat = $urandom;
        i_wb_sel = 4'($urandom_range(0, 15));
        i_wb_we  = 1'b0;
        i_wb_stb = 1'b1;
        t_drive  = cyc;
        got = 1'b0;
        n   = 0;
        while (!got && n < 400) begin
            @(negedge i_clk);
            n++;
            if (o_wb_ack) got = 1'b1;
            else if (n == drop_after) i_wb_stb = 1'b0;
        end
        i_wb_stb = 1'b0;
        t_ack    = cyc;
        check("ack_seen", {31'd0, got}, 32'd1);
        exp_q.push_back(exp_hdr(adr));
        check("rdata", o_wb_rdt, exp_data(adr));
    endtask

    task automatic check_hdrs();
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (hdr_q.size() == 0) check("hdr_missing", 32'd0, e);
            else check("mosi_hdr", hdr_q.pop_front(), e);
        end
    endtask

    task automatic read_alone(input logic [31:0] adr, input int drop_after);
        do_read(adr, drop_after);
        check("latency", 32'(t_ack - t_drive - 1), 32'd129);
        @(negedge i_clk);
        check("ack_one_cycle", {31'd0, o_wb_ack}, 32'd0);
        check_hdrs();
        repeat (3) @(negedge i_clk);
    endtask

    logic [31:0] last_rdt;
    int          t1;

    initial begin
        i_rst = 1'b1; i_wb_adr = 32'd0; i_wb_dat = 32'd0; i_wb_sel = 4'd0;
        i_wb_we = 1'b0; i_wb_stb = 1'b0;
        seed = 8'($urandom);
        ovr[24'h100010] = 8'h11; ovr[24'h100011] = 8'h22;
        ovr[24'h100012] = 8'h33; ovr[24'h100013] = 8'h44;
        repeat (3) @(negedge i_clk);
        check("rst_cs_n", {31'd0, o_spi_cs_n}, 32'd1);
        check("rst_sck", {31'd0, o_spi_sck}, 32'd0);
        check("rst_mosi", {31'd0, o_spi_mosi}, 32'd0);
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("rst_rdt", o_wb_rdt, 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Directed read with pinned flash bytes.
        read_alone(32'h0000_0010, 0);
        check("rdt_44332211", o_wb_rdt, 32'h4433_2211);
        last_rdt = o_wb_rdt;

        // Write: ack next cycle, no SPI activity, read data untouched.
        i_wb_adr = 32'h4; i_wb_dat = 32'hDEADBEEF; i_wb_sel = 4'hF;
        i_wb_we = 1'b1; i_wb_stb = 1'b1;
        @(negedge i_clk);
        check("wr_ack", {31'd0, o_wb_ack}, 32'd1);
        check("wr_cs_n", {31'd0, o_spi_cs_n}, 32'd1);
        check("wr_sck", {31'd0, o_spi_sck}, 32'd0);
        i_wb_stb = 1'b0; i_wb_we = 1'b0;
        @(negedge i_clk);
        check("wr_ack_drop", {31'd0, o_wb_ack}, 32'd0);
        check("wr_cs_n2", {31'd0, o_spi_cs_n}, 32'd1);
        check("wr_rdt_hold", o_wb_rdt, last_rdt);
        repeat (2) @(negedge i_clk);

        // Address wrap at the top of the flash window.
        read_alone(32'h00FF_FFFC, 0);

        // Back-to-back reads.
        do_read(32'h0000_0100, 0);
        t1 = t_ack;
        do_read(32'h0000_0204, 0);
        check("b2b_spacing", 32'(t_ack - t1), 32'd132);
        @(negedge i_clk);
        check_hdrs();
        repeat (3) @(negedge i_clk);

        // Strobe dropped mid-transfer still completes.
        read_alone($urandom, 10);

        // Random reads.
        for (int i = 0; i < 5; i++) read_alone($urandom, 0);

        // Reset in the middle of a read.
        i_wb_adr = 32'h0000_0040; i_wb_we = 1'b0; i_wb_stb = 1'b1;
        repeat (40) @(negedge i_clk);
        i_rst = 1'b1; i_wb_stb = 1'b0;
        @(negedge i_clk);
        check("mid_rst_cs_n", {31'd0, o_spi_cs_n}, 32'd1);
        check("mid_rst_sck", {31'd0, o_spi_sck}, 32'd0);
        check("mid_rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("mid_rst_rdt", o_wb_rdt, 32'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("post_rst_no_ack", {31'd0, o_wb_ack}, 32'd0);
        end
        check("aborted_no_hdr", 32'(hdr_q.size()), 32'd0);
        read_alone(32'h0000_0010, 0);
        for (int i = 0; i < 3; i++) read_alone($urandom, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
